// File: rtl/jvm_operand_queue_pkg.sv
// Shared constants for the JVM operand queue.
//   OPQ_WORD_W    : width of an extended operand
//   OPQ_LEN_W     : width of the byte-count field stored with each operand
//   OPQ_MAX_BYTES : longest operand the assembler accepts
//   opq_state_e   : assembler FSM encodings
package jvm_operand_queue_pkg;

  localparam int OPQ_WORD_W = 32;
  localparam int OPQ_LEN_W  = 3;
  localparam int OPQ_ENTRY_W = OPQ_LEN_W + OPQ_WORD_W;

  localparam logic [OPQ_LEN_W-1:0] OPQ_MAX_BYTES = 3'd4;

  typedef enum logic [1:0] {
    OPQ_IDLE  = 2'd0,
    OPQ_ACCUM = 2'd1,
    OPQ_HOLD  = 2'd2
  } opq_state_e;

endpackage

// File: rtl/jvm_operand_queue_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : empties the FIFO (same effect as reset on pointers/count)
//   push, push_data : write request; accepted when not full or when popping
//   pop          : read request; ignored while empty
//   rd_data      : head entry, combinational from the read pointer
//   count, full, empty : occupancy status
module jvm_operand_queue_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees the slot the push needs, so a full FIFO can still take a write.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/jvm_operand_queue.sv
// Assembles 1..4 MSB-first JVM operand bytes into one operand, sign- or
// zero-extends it to 32 bits and queues it for the ARM code emitter.
//   clk, reset          : clock, synchronous active-high reset
//   byte_valid/byte_in  : operand byte beat from instruction RAM
//   byte_last, sign_ext : final-byte marker and extension mode for it
//   flush               : drops the partial operand and all queued entries
//   out_ready           : consumer takes the head entry
//   out_valid/out_data/out_len : head entry (FWFT)
//   count               : FIFO occupancy
//   waiting             : stall request back to the bytecode state machine
//   overflow            : sticky, set on any dropped byte; cleared by reset
module jvm_operand_queue
  import jvm_operand_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  input  logic                  byte_last,
  input  logic                  sign_ext,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [OPQ_WORD_W-1:0] out_data,
  output logic [OPQ_LEN_W-1:0]  out_len,
  output logic [CNT_W-1:0]      count,
  output logic                  waiting,
  output logic                  overflow
);

  opq_state_e state_q, state_d;

  // Only the three most recent bytes can still matter once the last one arrives.
  logic [23:0]            acc_q, acc_d;
  logic [OPQ_LEN_W-1:0]   nbytes_q, nbytes_d;
  logic [OPQ_ENTRY_W-1:0] hold_q, hold_d;
  logic                   overflow_q, overflow_d;

  logic                   fifo_push;
  logic [OPQ_ENTRY_W-1:0] fifo_push_data;
  logic [OPQ_ENTRY_W-1:0] fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop_fire;
  logic                   fifo_space;
  logic [OPQ_LEN_W-1:0]   last_len;
  logic [OPQ_WORD_W-1:0]  word;
  logic [OPQ_WORD_W-1:0]  word_ext;

  function automatic logic [OPQ_WORD_W-1:0] extend(input logic [OPQ_WORD_W-1:0] w,
                                                   input logic [OPQ_LEN_W-1:0] len,
                                                   input logic sx);
    logic [OPQ_WORD_W-1:0] r;
    case (len)
      3'd1:    r = {{24{sx & w[7]}},  w[7:0]};
      3'd2:    r = {{16{sx & w[15]}}, w[15:0]};
      3'd3:    r = {{8{sx & w[23]}},  w[23:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign pop_fire   = out_ready & ~fifo_empty;
  assign fifo_space = ~fifo_full | pop_fire;
  assign last_len   = nbytes_q + 3'd1;
  assign word       = {acc_q, byte_in};
  assign word_ext   = extend(word, last_len, sign_ext);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OPQ_IDLE;
      acc_q      <= '0;
      nbytes_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      nbytes_q   <= nbytes_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  // Next-state and assembler update; flush overrides every other input.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    nbytes_d       = nbytes_q;
    hold_d         = hold_q;
    overflow_d     = overflow_q;
    fifo_push      = 1'b0;
    fifo_push_data = hold_q;
    if (flush) begin
      state_d  = OPQ_IDLE;
      acc_d    = '0;
      nbytes_d = '0;
    end else if (state_q == OPQ_HOLD) begin
      if (byte_valid) begin
        overflow_d = 1'b1;
      end
      if (fifo_space) begin
        fifo_push = 1'b1;
        state_d   = OPQ_IDLE;
      end
    end else if (byte_valid) begin
      if (!byte_last) begin
        if (nbytes_q == OPQ_MAX_BYTES) begin
          overflow_d = 1'b1;
        end else begin
          acc_d    = {acc_q[15:0], byte_in};
          nbytes_d = nbytes_q + 3'd1;
          state_d  = OPQ_ACCUM;
        end
      end else begin
        // Every outcome of a last byte leaves the assembler empty.
        acc_d    = '0;
        nbytes_d = '0;
        state_d  = OPQ_IDLE;
        if (nbytes_q == OPQ_MAX_BYTES) begin
          overflow_d = 1'b1;
        end else if (fifo_space) begin
          fifo_push      = 1'b1;
          fifo_push_data = {last_len, word_ext};
        end else begin
          hold_d  = {last_len, word_ext};
          state_d = OPQ_HOLD;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    waiting   = fifo_full | (state_q == OPQ_HOLD);
    out_valid = ~fifo_empty;
    out_data  = fifo_rd_data[OPQ_WORD_W-1:0];
    out_len   = fifo_rd_data[OPQ_ENTRY_W-1:OPQ_WORD_W];
    overflow  = overflow_q;
  end

  jvm_operand_queue_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OPQ_ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (out_ready),
    .rd_data   (fifo_rd_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_jvm_operand_queue.sv
module tb_jvm_operand_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_in = 8'h00;
  logic             byte_last = 1'b0;
  logic             sign_ext = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [31:0]      out_data;
  logic [2:0]       out_len;
  logic [CNT_W-1:0] count;
  logic             waiting;
  logic             overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jvm_operand_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_last  (byte_last),
    .sign_ext   (sign_ext),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_len    (out_len),
    .count      (count),
    .waiting    (waiting),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] b, input logic l,
                      input logic sx, input logic rdy, input logic fl);
    byte_valid = v;
    byte_in    = b;
    byte_last  = l;
    sign_ext   = sx;
    out_ready  = rdy;
    flush      = fl;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp_data, input logic [2:0] exp_len);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_len"}, 32'(out_len), 32'(exp_len));
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_waiting", 32'(waiting), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single byte, sign-extended
    step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t1_count", 32'(count), 32'd1);
    pop_check("t1", 32'hFFFF_FFFF, 3'd1);
    check("t1_drained", 32'(count), 32'd0);

    // Two bytes, zero- then sign-extended
    step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_check("t2z", 32'h0000_8001, 3'd2);
    step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    pop_check("t2s", 32'hFFFF_8001, 3'd2);

    // Three and four bytes
    step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    pop_check("t3s", 32'hFF80_0001, 3'd3);
    step(1'b1, 8'h92, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_check("t4z", 32'h9234_5678, 3'd4);

    // Push into an empty FIFO while out_ready is high: pop ignored, push lands
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
    check("emptypush_count", 32'(count), 32'd1);
    pop_check("emptypush", 32'h0000_0033, 3'd1);

    // Fill, then HOLD, then a pop that lets the held entry in
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_waiting", 32'(waiting), 32'd1);
    step(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_count", 32'(count), 32'd4);
    check("hold_waiting", 32'(waiting), 32'd1);
    check("hold_overflow", 32'(overflow), 32'd0);
    pop_check("hold_pop01", 32'h0000_0001, 3'd1);
    check("hold_refill_count", 32'(count), 32'd4);
    pop_check("ord02", 32'h0000_0002, 3'd1);
    check("ord_waiting_drop", 32'(waiting), 32'd0);
    check("ord_count3", 32'(count), 32'd3);
    pop_check("ord03", 32'h0000_0003, 3'd1);
    pop_check("ord04", 32'h0000_0004, 3'd1);
    pop_check("ord05", 32'h0000_0005, 3'd1);
    check("ord_empty", 32'(out_valid), 32'd0);

    // Full FIFO with simultaneous last-byte push and pop
    for (int i = 6; i <= 9; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0A, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pp_count", 32'(count), 32'd4);
    check("pp_overflow", 32'(overflow), 32'd0);
    pop_check("pp07", 32'h0000_0007, 3'd1);
    check("pp_no_hold", 32'(waiting), 32'd0);
    pop_check("pp08", 32'h0000_0008, 3'd1);
    pop_check("pp09", 32'h0000_0009, 3'd1);
    pop_check("pp0a", 32'h0000_000A, 3'd1);

    // Too many bytes
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_before", 32'(overflow), 32'd0);
    step(1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_after5", 32'(overflow), 32'd1);
    step(1'b1, 8'h16, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ovf_dropped", 32'(count), 32'd0);
    step(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_check("ovf_cleared_asm", 32'h0000_007E, 3'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_survives_flush", 32'(overflow), 32'd1);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("ovf_reset", 32'(overflow), 32'd0);

    // Mid-operand flush with entries queued
    step(1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fl_pre_count", 32'(count), 32'd2);
    step(1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b1);
    check("fl_count", 32'(count), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    step(1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    pop_check("fl_7f", 32'h0000_007F, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
